// File: rtl/config_load_sequencer_if.sv
// config_load_sequencer_if: config-word stream, latch-bank drive and status signals of the load sequencer
interface config_load_sequencer_if #(
   parameter int NUM_WORDS = 32,
   parameter int WORD_W    = 32,
   parameter int IDX_W     = 5
);
   logic                 io_start;
   logic                 io_abort;
   logic                 io_in_valid;
   logic                 io_in_ready;
   logic [WORD_W-1:0]    io_in_data;
   logic [WORD_W-1:0]    io_d_in;
   logic [NUM_WORDS-1:0] io_configs_en;
   logic [IDX_W-1:0]     io_word_idx;
   logic                 io_busy;
   logic                 io_done;
   logic                 io_error;
   modport master (
      output io_start, io_abort, io_in_valid, io_in_data,
      input  io_in_ready, io_d_in, io_configs_en, io_word_idx, io_busy, io_done, io_error
   );
   modport slave (
      input  io_start, io_abort, io_in_valid, io_in_data,
      output io_in_ready, io_d_in, io_configs_en, io_word_idx, io_busy, io_done, io_error
   );
endinterface

// File: rtl/config_load_sequencer.sv
// config_load_sequencer: strobes config words into the 32x32 latch bank with data setup/hold around each enable.
// Define CFG_SEQ_CHECKSUM_EN to accept a trailing XOR checksum word and flag mismatches on io_error.
module config_load_sequencer #(
   parameter int NUM_WORDS     = 32,
   parameter int WORD_W        = 32,
   parameter int STROBE_CYCLES = 1,
   parameter int IDX_W         = 5
) (
   input logic                    clk,
   input logic                    reset,
   config_load_sequencer_if.slave bus
);
   localparam int CNT_W = STROBE_CYCLES > 1 ? $clog2(STROBE_CYCLES) : 1;
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ACCEPT = 3'd1;
   localparam logic [2:0] SETUP  = 3'd2;
   localparam logic [2:0] STROBE = 3'd3;
   localparam logic [2:0] HOLD   = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;
`ifdef CFG_SEQ_CHECKSUM_EN
   localparam logic [2:0] CHECK  = 3'd6;
`endif

   logic [2:0]           r_state, w_nxt;
   logic [IDX_W-1:0]     r_idx;
   logic [CNT_W-1:0]     r_cnt;
   logic [WORD_W-1:0]    r_d;
   logic [NUM_WORDS-1:0] r_en;
   logic                 w_last, w_cnt_end, w_acc, w_start;

   assign w_last    = r_idx == IDX_W'(NUM_WORDS - 1);
   assign w_cnt_end = r_cnt == CNT_W'(STROBE_CYCLES - 1);
   assign w_acc     = r_state == ACCEPT && bus.io_in_valid && !bus.io_abort;
   assign w_start   = r_state == IDLE && w_nxt == ACCEPT;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    w_nxt = bus.io_start ? ACCEPT : IDLE;
         ACCEPT:  w_nxt = bus.io_in_valid ? SETUP : ACCEPT;
         SETUP:   w_nxt = STROBE;
         STROBE:  w_nxt = w_cnt_end ? HOLD : STROBE;
`ifdef CFG_SEQ_CHECKSUM_EN
         HOLD:    w_nxt = w_last ? CHECK : ACCEPT;
         CHECK:   w_nxt = bus.io_in_valid ? DONE : CHECK;
`else
         HOLD:    w_nxt = w_last ? DONE : ACCEPT;
`endif
         default: w_nxt = IDLE;
      endcase
      if (bus.io_abort) w_nxt = IDLE;
   end

   // Enables are registered from the next state so they never glitch and reset clears them at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_d     <= '0;
         r_en    <= '0;
      end else begin
         r_state <= w_nxt;
         r_en    <= w_nxt == STROBE ? NUM_WORDS'(1) << r_idx : '0;
         r_cnt   <= r_state == STROBE ? r_cnt + CNT_W'(1) : '0;
         if (r_state == IDLE) r_idx <= '0;
         else if (r_state == HOLD && w_nxt == ACCEPT) r_idx <= r_idx + IDX_W'(1);
         if (w_acc) r_d <= bus.io_in_data;
      end
   end

`ifdef CFG_SEQ_CHECKSUM_EN
   logic [WORD_W-1:0] r_xor;
   logic              r_err;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_xor <= '0;
         r_err <= 1'b0;
      end else if (w_start) begin
         r_xor <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_acc) r_xor <= r_xor ^ bus.io_in_data;
         if (r_state == CHECK && bus.io_in_valid && !bus.io_abort) r_err <= bus.io_in_data != r_xor;
      end
   end
   assign bus.io_error    = r_err;
   assign bus.io_in_ready = r_state == ACCEPT || r_state == CHECK;
`else
   assign bus.io_error    = 1'b0;
   assign bus.io_in_ready = r_state == ACCEPT;
`endif

   assign bus.io_d_in       = r_d;
   assign bus.io_configs_en = r_en;
   assign bus.io_word_idx   = r_state == IDLE ? '0 : r_idx;
   assign bus.io_busy       = r_state != IDLE;
   assign bus.io_done       = r_state == DONE;
endmodule
